// File: rtl/transfer_sequencer_if.sv
// rtl/transfer_sequencer_if.sv - request and memory-path signals of transfer_sequencer
interface transfer_sequencer_if #(
  parameter int ID_W  = 4,
  parameter int BAL_W = 16
);
  // request side
  logic             start;
  logic [ID_W-1:0]  sender_id;
  logic [ID_W-1:0]  receiver_id;
  logic [BAL_W-1:0] amount;
  logic             busy;
  logic             txn_done;
  logic             txn_ok;
  logic [1:0]       err_code;
  // memory_control side
  logic             mem_done;
  logic [BAL_W-1:0] rd_balance;
  logic             load_memory;
  logic [2:0]       process;
  logic [ID_W-1:0]  mem_addr;
  logic [BAL_W-1:0] wr_balance;

  // the sequencer itself
  modport slave (
    input  start, sender_id, receiver_id, amount, mem_done, rd_balance,
    output load_memory, process, mem_addr, wr_balance, busy, txn_done, txn_ok, err_code
  );

  // the environment: requester plus memory_control
  modport master (
    output start, sender_id, receiver_id, amount, mem_done, rd_balance,
    input  load_memory, process, mem_addr, wr_balance, busy, txn_done, txn_ok, err_code
  );
endinterface

// File: rtl/transfer_sequencer.sv
// rtl/transfer_sequencer.sv - one debit/credit coin transfer per request; TXN_TIMEOUT_EN enables the write watchdog
module transfer_sequencer #(
  parameter int ID_W      = 4,
  parameter int BAL_W     = 16,
  parameter int LOAD_WAIT = 10,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 resetn,
  transfer_sequencer_if.slave  bus
);

`ifdef TXN_TIMEOUT_EN
  localparam bit WDOG_EN = 1'b1;
`else
  localparam bit WDOG_EN = 1'b0;
`endif

  localparam int LW_W = $clog2(LOAD_WAIT + 1);
  localparam int WD_W = $clog2(TIMEOUT + 1);

  // state encoding doubles as the process code seen by memory_control
  typedef enum logic [2:0] {
    IDLE    = 3'b000,
    LOAD_S  = 3'b001,
    CALC_S  = 3'b010,
    LOAD_R  = 3'b011,
    COMMIT  = 3'b100,
    WAIT_WR = 3'b101,
    CALC_R  = 3'b110,
    FINISH  = 3'b111
  } state_t;

  state_t           state_q;
  logic [ID_W-1:0]  sender_q;
  logic [ID_W-1:0]  receiver_q;
  logic [BAL_W-1:0] amount_q;
  logic [BAL_W-1:0] rd_q;
  logic             funds_ok_q;
  logic             phase_q;      // 0: sender access, 1: receiver access
  logic [LW_W-1:0]  cnt_q;
  logic [WD_W-1:0]  wd_q;
  logic             load_memory_q;
  logic [ID_W-1:0]  mem_addr_q;
  logic [BAL_W-1:0] wr_balance_q;
  logic             busy_q;
  logic             txn_done_q;
  logic             txn_ok_q;
  logic [1:0]       err_q;

  logic             funds_ok_d;
  logic [BAL_W-1:0] debit_d;
  logic [BAL_W-1:0] credit_d;

  assign funds_ok_d = (rd_q >= amount_q);
  assign debit_d    = rd_q - amount_q;
  assign credit_d   = rd_q + amount_q;   // wraps; total supply stays below 2^BAL_W

  // transfer sequencing FSM with registered outputs
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state_q       <= IDLE;
      sender_q      <= '0;
      receiver_q    <= '0;
      amount_q      <= '0;
      rd_q          <= '0;
      funds_ok_q    <= 1'b0;
      phase_q       <= 1'b0;
      cnt_q         <= '0;
      wd_q          <= '0;
      load_memory_q <= 1'b0;
      mem_addr_q    <= '0;
      wr_balance_q  <= '0;
      busy_q        <= 1'b0;
      txn_done_q    <= 1'b0;
      txn_ok_q      <= 1'b0;
      err_q         <= 2'b00;
    end else begin
      load_memory_q <= 1'b0;
      txn_done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.start && bus.mem_done) begin
            sender_q   <= bus.sender_id;
            receiver_q <= bus.receiver_id;
            amount_q   <= bus.amount;
            busy_q     <= 1'b1;
            txn_ok_q   <= 1'b0;
            err_q      <= 2'b00;
            funds_ok_q <= 1'b0;
            phase_q    <= 1'b0;
            if (bus.sender_id == bus.receiver_id) begin
              // self-transfer is rejected without touching memory
              err_q   <= 2'b10;
              state_q <= FINISH;
            end else begin
              mem_addr_q    <= bus.sender_id;
              load_memory_q <= 1'b1;
              cnt_q         <= '0;
              state_q       <= LOAD_S;
            end
          end
        end
        LOAD_S, LOAD_R: begin
          if (cnt_q == LW_W'(LOAD_WAIT - 1)) begin
            rd_q    <= bus.rd_balance;
            cnt_q   <= '0;
            state_q <= (state_q == LOAD_S) ? CALC_S : CALC_R;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        CALC_S: begin
          // short funds still write back the old balance to release memory_control
          wr_balance_q <= funds_ok_d ? debit_d : rd_q;
          funds_ok_q   <= funds_ok_d;
          state_q      <= COMMIT;
        end
        CALC_R: begin
          wr_balance_q <= credit_d;
          state_q      <= COMMIT;
        end
        COMMIT: begin
          wd_q    <= '0;
          state_q <= WAIT_WR;
        end
        WAIT_WR: begin
          if (bus.mem_done) begin
            wd_q <= '0;
            if (!phase_q && funds_ok_q) begin
              phase_q       <= 1'b1;
              mem_addr_q    <= receiver_q;
              load_memory_q <= 1'b1;
              cnt_q         <= '0;
              state_q       <= LOAD_R;
            end else begin
              err_q   <= phase_q ? 2'b00 : 2'b01;
              state_q <= FINISH;
            end
          end else if (WDOG_EN && (wd_q == WD_W'(TIMEOUT - 1))) begin
            wd_q    <= '0;
            err_q   <= 2'b11;
            state_q <= FINISH;
          end else if (WDOG_EN) begin
            wd_q <= wd_q + 1'b1;
          end
        end
        FINISH: begin
          txn_done_q <= 1'b1;
          txn_ok_q   <= (err_q == 2'b00);
          busy_q     <= 1'b0;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.load_memory = load_memory_q;
  assign bus.process     = state_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.wr_balance  = wr_balance_q;
  assign bus.busy        = busy_q;
  assign bus.txn_done    = txn_done_q;
  assign bus.txn_ok      = txn_ok_q;
  assign bus.err_code    = err_q;

endmodule
